byte_lane_arbiter: RTL and testbench

//   Round-robin arbiter sharing one DW-bit operand bus between N_REQ requesters.
//   - Grants one owner at a time.
//   - Holds the grant for a burst of up to MAX_HOLD transfers.
//   - Drives the bus through an AND-OR mux using per-requester byte-replicated grant masks.
//   - Sits between the operand sources and the shared bus consumer (bus_ready handshake).
//

---
 rtl/byte_lane_arbiter_pkg.sv | 13 +
 rtl/byte_lane_arbiter_rr_pick.sv | 26 ++
 rtl/byte_lane_arbiter.sv | 111 +++++++++++
 tb/tb_byte_lane_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/byte_lane_arbiter_pkg.sv
// Shared definitions for the byte-lane arbiter: FSM state encoding and default sizing.
package byte_lane_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DW       = 8;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/byte_lane_arbiter_rr_pick.sv
// Combinational round-robin search: first requester at or after start, wrapping.
module rr_pick
  import byte_lane_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int OW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    start,
  output logic             found,
  output logic [OW-1:0]    winner
);

  // Walk the ring backwards so the candidate closest to start is written last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(start) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = OW'((int'(start) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/byte_lane_arbiter.sv
// Round-robin owner of a shared DW-bit bus with bounded burst length and
// an AND-OR data mux driven by byte-replicated grant masks.
module byte_lane_arbiter
  import byte_lane_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DW       = DEF_DW,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int OW = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data_in,
  input  logic                bus_ready,
  output logic [N_REQ-1:0]    gnt,
  output logic [OW-1:0]       owner,
  output logic                bus_valid,
  output logic [DW-1:0]       bus_data
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic [OW-1:0]    start;
  logic             found;
  logic [OW-1:0]    winner;
  logic             xfer;
  logic             last_xfer;
  logic [DW-1:0]    masked [N_REQ];

  // Both the idle pick and the release pick begin one past the current owner.
  assign start = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .start  (start),
    .found  (found),
    .winner (winner)
  );

  assign bus_valid = (|gnt_q) && req[owner_q];
  assign xfer      = bus_valid && bus_ready;
  assign last_xfer = xfer && (hold_q == HW'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = N_REQ'(1) << winner;
          owner_d = winner;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner_q] || last_xfer) begin
          if (found) begin
            gnt_d   = N_REQ'(1) << winner;
            owner_d = winner;
            hold_d  = '0;
          end else begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (xfer) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= OW'(N_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_mask
    assign masked[i] = data_in[i*DW +: DW] & {DW{gnt_q[i]}};
  end

  always_comb begin
    bus_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus_data = bus_data | masked[i];
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// Randomized and directed stimulus for byte_lane_arbiter, scored against a
// burst-level ownership model through an expectation queue.
module tb_byte_lane_arbiter;

  localparam int N_REQ    = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;
  localparam int OW       = $clog2(N_REQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data_in;
  logic                bus_ready;
  logic [N_REQ-1:0]    gnt;
  logic [OW-1:0]       owner;
  logic                bus_valid;
  logic [DW-1:0]       bus_data;

  typedef struct {
    logic [N_REQ-1:0] gnt;
    logic [OW-1:0]    owner;
    logic             valid;
    logic [DW-1:0]    data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: who owns the bus and how many beats of the burst are used.
  bit m_active;
  int m_owner;
  int m_beats;

  always #5 clk = ~clk;

  byte_lane_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .bus_ready (bus_ready),
    .gnt       (gnt),
    .owner     (owner),
    .bus_valid (bus_valid),
    .bus_data  (bus_data)
  );

  function automatic int next_owner(int last, logic [N_REQ-1:0] r);
    for (int k = 1; k <= N_REQ; k++) begin
      if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_owner  = N_REQ - 1;
    m_beats  = 0;
  endtask

  task automatic do_cycle(input logic r, input logic [N_REQ-1:0] rq, input logic rdy);
    exp_t e;
    bit   beat;
    int   w;
    @(negedge clk);
    rst       = r;
    req       = rq;
    bus_ready = rdy;
    for (int i = 0; i < N_REQ; i++) data_in[i*DW +: DW] = DW'($urandom);
    e.gnt   = m_active ? N_REQ'(1 << m_owner) : '0;
    e.owner = OW'(m_owner);
    e.valid = m_active && rq[m_owner];
    e.data  = m_active ? data_in[m_owner*DW +: DW] : '0;
    exp_q.push_back(e);
    beat = e.valid && rdy;
    if (r) begin
      model_reset();
    end else if (!m_active) begin
      w = next_owner(m_owner, rq);
      if (w >= 0) begin
        m_active = 1;
        m_owner  = w;
        m_beats  = 0;
      end
    end else if (!rq[m_owner] || (beat && m_beats + 1 == MAX_HOLD)) begin
      w = next_owner(m_owner, rq);
      m_beats = 0;
      if (w >= 0) m_owner = w;
      else m_active = 0;
    end else if (beat) begin
      m_beats++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("owner", 32'(owner), 32'(e.owner));
        check("bus_valid", 32'(bus_valid), 32'(e.valid));
        check("bus_data", 32'(bus_data), 32'(e.data));
      end
    end
  end

  initial begin : stimulus
    rst       = 1'b1;
    req       = '0;
    data_in   = '0;
    bus_ready = 1'b0;
    model_reset();
    @(posedge clk);

    // Reset held with everyone requesting, then round robin with full throughput.
    repeat (2) do_cycle(1'b1, 4'hF, 1'b1);
    repeat (20) do_cycle(1'b0, 4'hF, 1'b1);

    // Sole requester re-wins after its burst expires.
    do_cycle(1'b1, 4'h0, 1'b1);
    repeat (10) do_cycle(1'b0, 4'b0100, 1'b1);

    // Backpressure mid-burst freezes ownership and beat count.
    do_cycle(1'b1, 4'h0, 1'b1);
    repeat (3) do_cycle(1'b0, 4'b0010, 1'b1);
    repeat (5) do_cycle(1'b0, 4'b1010, 1'b0);
    repeat (6) do_cycle(1'b0, 4'b1010, 1'b1);

    // Early drop with another requester pending, then with nobody pending.
    do_cycle(1'b1, 4'h0, 1'b1);
    repeat (3) do_cycle(1'b0, 4'b0010, 1'b1);
    repeat (3) do_cycle(1'b0, 4'b1000, 1'b1);
    repeat (3) do_cycle(1'b0, 4'b0000, 1'b1);

    // Reset pulse in the middle of a burst.
    do_cycle(1'b1, 4'h0, 1'b1);
    repeat (2) do_cycle(1'b0, 4'b0100, 1'b1);
    do_cycle(1'b1, 4'b0100, 1'b1);
    repeat (6) do_cycle(1'b0, 4'hF, 1'b1);

    // Random traffic with occasional resets.
    repeat (600) begin
      logic [N_REQ-1:0] rq;
      for (int i = 0; i < N_REQ; i++) rq[i] = ($urandom_range(0, 9) < 6);
      do_cycle(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
